adc_sample_avg: RTL and testbench
=================================

Name: adc_sample_avg

Overview:
- Sits directly downstream of the AD7671 16-bit serial reader.
- Takes each converted sample plus a one-cycle strobe and accumulates 2^LOG2_N samples into a boxcar sum.
- Presents the decimated average on a valid/ready output toward buffering or host logic.
- Tracks results dropped due to consumer back-pressure.

Parameters:
- DATA_W, 16: sample width, input and output.
- LOG2_N, 2: log2 of samples per average, legal 0..8; N = 2^LOG2_N.
- SIGNED_IN, 0: 0 = straight binary (zero-extend), 1 = two's complement (sign-extend, arithmetic shift).

Ports:
- clk_in  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = accumulate; 0 = flush partial accumulation.
- s_data  in  DATA_W  sample from the reader.
- s_valid  in  1  one-cycle strobe; s_data is valid this cycle.
- m_data  out  DATA_W  averaged sample.
- m_valid  out  1  m_data holds an unconsumed result.
- m_ready  in  1  consumer accepts when m_valid & m_ready.
- drop_cnt  out  8  saturating count of discarded results.
- ovf_clr  in  1  clears drop_cnt.
- busy  out  1  high when the sample count is not 0.

Behaviour:
- **Reset** (rst=1 on a clock edge):
  - acc=0, cnt=0, m_data=0, m_valid=0, drop_cnt=0, busy=0.
  - rst overrides every other input, including mid-accumulation and a pending m_valid.
- **Accumulator:**
  - Width is DATA_W+LOG2_N, so there is no internal overflow.
  - The sample is extended per SIGNED_IN before adding.
- **Sample counter:**
  - cnt is LOG2_N bits wide (1 bit, unused, when LOG2_N=0).
  - Terminal when cnt==N-1, or always when LOG2_N=0.
- **Accumulation** (enable=1, s_valid=1):
  - Non-terminal: acc<=acc+ext(s_data), cnt<=cnt+1.
  - Terminal:
    - Result = (acc+ext(s_data)) >> LOG2_N, arithmetic when SIGNED_IN=1, taking the low DATA_W bits.
    - acc<=0, cnt<=0.
    - The terminal sample is always included in its own result.
- **Output state machine** (states EMPTY / FULL, reflected by m_valid):
  - EMPTY, result produced → m_data<=result, m_valid<=1 on the next edge. Latency: terminal s_valid at cycle t gives m_valid=1 at t+1.
  - FULL, m_ready=1, no result → m_valid<=0 next cycle; m_data holds its value.
  - FULL, m_ready=1, result same cycle → m_data<=result, m_valid stays 1, no drop.
  - FULL, m_ready=0, result same cycle → result discarded, m_data unchanged, drop_cnt<=drop_cnt+1 saturating at 255.
  - m_data must stay stable while m_valid=1 and m_ready=0.
- **drop_cnt:**
  - ovf_clr=1 sets drop_cnt<=0.
  - ovf_clr and a drop in the same cycle → drop_cnt<=1.
- **Flush** (enable=0):
  - acc<=0, cnt<=0; s_valid is ignored.
  - Output state, m_data and drop_cnt are unaffected; a pending result can still be consumed.
  - A partial window is discarded, never emitted.
  - Re-enabling starts a fresh window.
- **busy** = (cnt!=0), registered.
- **LOG2_N=0:** pass-through with one cycle of latency; every sample is a result.
- **s_valid on consecutive cycles:** supported; no throughput limit on the input side.

Optional Feature:
- Macro: ADC_AVG_ROUND_EN.
- **Defined:** add 2^(LOG2_N-1) to the full sum before the shift, giving round-half-up (toward +inf for signed). No rounding applies when LOG2_N=0. The addition happens at the accumulator width plus one guard bit so it cannot wrap. At the top code, the result saturates to max (0xFFFF unsigned, 0x7FFF signed).
- **Not defined:** plain truncation (floor).

Test Plan:
- Reset, then LOG2_N=2, SIGNED_IN=0, enable=1; strobe 100,101,102,103 with m_ready=1 → m_data=101 (0x0065) with macro off, 102 with ROUND_EN; m_valid pulses one cycle, one cycle after the 4th strobe.
- SIGNED_IN=1, samples 0xFFFF,0xFFFE,0xFFFD,0xFFFC (-1..-4) → m_data=0xFFFD (-3) truncate, 0xFFFE (-2) rounded.
- m_ready=0; feed 8 samples of 0x1000 → first result 0x1000 held with m_valid=1, second dropped, drop_cnt=1; then assert ovf_clr → drop_cnt=0.
- Result pending with m_ready=1 in the same cycle as the next terminal sample → new m_data loaded, m_valid continuous, drop_cnt stays 0.
- Feed 2 samples, enable=0 for one cycle, enable=1, feed 4 samples of 0x0200 → single result 0x0200; busy=1 after the first sample, 0 after the flush.
- Assert rst with cnt=3 and m_valid=1 → next cycle m_valid=0, m_data=0, busy=0, drop_cnt=0; then four samples of 0xFFFF unsigned → 0xFFFF in both truncate and rounded builds.

Source files
------------

// File: rtl/adc_sample_avg.sv
// rtl/adc_sample_avg.sv - boxcar average of 2^LOG2_N ADC samples onto a valid/ready output
// Optional round-half-up with top-code saturation when ADC_AVG_ROUND_EN is defined.
module adc_sample_avg #(
  parameter int DATA_W    = 16,
  parameter int LOG2_N    = 2,
  parameter int SIGNED_IN = 0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        drop_cnt,
  input  logic              ovf_clr,
  output logic              busy
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_m_data;
  logic [7:0]        r_drop_cnt;

  logic [ACC_W-1:0]  w_ext;
  logic [ACC_W-1:0]  w_sum;
  logic              w_term;
  logic              w_res_vld;
  logic              w_drop;
  logic [DATA_W-1:0] w_result;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  always_comb begin
    w_ext = ACC_W'(s_data);
    if (SIGNED_IN != 0) begin
      w_ext = ACC_W'($signed(s_data));
    end
  end

  assign w_sum     = r_acc + w_ext;
  assign w_term    = (LOG2_N == 0) || (r_cnt == CNT_LAST);
  assign w_res_vld = enable && s_valid && w_term;
  assign w_drop    = (r_state == S_FULL) && !m_ready && w_res_vld;

`ifdef ADC_AVG_ROUND_EN
  // One guard bit above the accumulator keeps the half-LSB addition from wrapping.
  localparam int RND_SH = (LOG2_N > 0) ? LOG2_N - 1 : 0;
  localparam logic [ACC_W:0] RND = (LOG2_N == 0) ? '0 : ((ACC_W+1)'(1) << RND_SH);

  logic [ACC_W:0] w_sum_g;
  logic [ACC_W:0] w_shift;

  always_comb begin
    w_sum_g  = {((SIGNED_IN != 0) ? w_sum[ACC_W-1] : 1'b0), w_sum} + RND;
    w_shift  = w_sum_g >> LOG2_N;
    w_result = w_shift[DATA_W-1:0];
    if (SIGNED_IN != 0) begin
      w_shift  = $signed(w_sum_g) >>> LOG2_N;
      w_result = w_shift[DATA_W-1:0];
      if (!w_shift[ACC_W] && (|w_shift[ACC_W-1:DATA_W-1])) begin
        w_result = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end else if (|w_shift[ACC_W:DATA_W]) begin
      w_result = '1;
    end
  end
`else
  always_comb begin
    w_result = DATA_W'(w_sum >> LOG2_N);
    if (SIGNED_IN != 0) begin
      w_result = DATA_W'($signed(w_sum) >>> LOG2_N);
    end
  end
`endif

  // Disable flushes the partial window; a terminal sample restarts it.
  always_comb begin
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;
    if (!enable) begin
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
    end else if (s_valid) begin
      if (w_term) begin
        w_acc_nxt = '0;
        w_cnt_nxt = '0;
      end else begin
        w_acc_nxt = w_sum;
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_state    <= S_EMPTY;
      r_m_data   <= '0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_cnt  <= w_cnt_nxt;
      r_busy <= |w_cnt_nxt;
      case (r_state)
        S_EMPTY: begin
          if (w_res_vld) begin
            r_m_data <= w_result;
            r_state  <= S_FULL;
          end
        end
        default: begin
          if (m_ready) begin
            if (w_res_vld) begin
              r_m_data <= w_result;
            end else begin
              r_state <= S_EMPTY;
            end
          end
        end
      endcase
      if (ovf_clr) begin
        r_drop_cnt <= {7'd0, w_drop};
      end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign m_data   = r_m_data;
  assign m_valid  = (r_state == S_FULL);
  assign drop_cnt = r_drop_cnt;
  assign busy     = r_busy;

endmodule

// File: tb/tb_adc_sample_avg.sv
// tb/tb_adc_sample_avg.sv - bench for adc_sample_avg, unsigned and signed instances side by side
// Honours ADC_AVG_ROUND_EN in its reference model.
module tb_adc_sample_avg;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  logic        clk_in;
  logic        rst;
  logic        enable;
  logic [15:0] s_data;
  logic        s_valid;
  logic        m_ready;
  logic        ovf_clr;

  logic [15:0] m_data_u, m_data_s;
  logic        m_valid_u, m_valid_s;
  logic [7:0]  drop_cnt_u, drop_cnt_s;
  logic        busy_u, busy_s;

  int          n_tests;
  int          n_fail;

  int          win[$];
  logic        exp_valid;
  logic [15:0] exp_data_u, exp_data_s;
  logic [7:0]  exp_drop;
  logic        exp_busy;

  adc_sample_avg #(.DATA_W(16), .LOG2_N(LOG2_N), .SIGNED_IN(0)) dut_u (
    .clk_in(clk_in), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .m_data(m_data_u), .m_valid(m_valid_u), .m_ready(m_ready), .drop_cnt(drop_cnt_u),
    .ovf_clr(ovf_clr), .busy(busy_u)
  );

  adc_sample_avg #(.DATA_W(16), .LOG2_N(LOG2_N), .SIGNED_IN(1)) dut_s (
    .clk_in(clk_in), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .m_data(m_data_s), .m_valid(m_valid_s), .m_ready(m_ready), .drop_cnt(drop_cnt_s),
    .ovf_clr(ovf_clr), .busy(busy_s)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] avg_u(input int w[$]);
    longint sum;
    longint res;
    sum = 0;
    foreach (w[i]) sum += w[i];
`ifdef ADC_AVG_ROUND_EN
    if (LOG2_N > 0) sum += N / 2;
`endif
    res = sum / N;
    if (res > 65535) res = 65535;
    return 16'(res);
  endfunction

  function automatic logic [15:0] avg_s(input int w[$]);
    longint sum;
    longint res;
    sum = 0;
    foreach (w[i]) sum += (w[i] >= 32768) ? w[i] - 65536 : w[i];
`ifdef ADC_AVG_ROUND_EN
    if (LOG2_N > 0) sum += N / 2;
`endif
    res = sum / N;
    if ((sum % N != 0) && (sum < 0)) res -= 1;
    if (res > 32767) res = 32767;
    if (res < -32768) res = -32768;
    return 16'(res);
  endfunction

  // Advance the reference model by one clock, drive the inputs, and settle past the edge.
  task automatic cycle(input logic en, input logic sv, input logic [15:0] d,
                       input logic rdy, input logic clr, input logic rs);
    logic res;
    logic drop;
    logic [15:0] ru, rsg;
    res = 1'b0;
    ru  = 16'd0;
    rsg = 16'd0;
    if (rs) begin
      win.delete();
      exp_valid  = 1'b0;
      exp_data_u = 16'd0;
      exp_data_s = 16'd0;
      exp_drop   = 8'd0;
      exp_busy   = 1'b0;
    end else begin
      if (!en) begin
        win.delete();
      end else if (sv) begin
        win.push_back(int'(d));
        if (win.size() == N) begin
          res = 1'b1;
          ru  = avg_u(win);
          rsg = avg_s(win);
          win.delete();
        end
      end
      drop = exp_valid && !rdy && res;
      if (!exp_valid || rdy) begin
        if (res) begin
          exp_valid  = 1'b1;
          exp_data_u = ru;
          exp_data_s = rsg;
        end else if (exp_valid) begin
          exp_valid = 1'b0;
        end
      end
      if (clr) exp_drop = drop ? 8'd1 : 8'd0;
      else if (drop && exp_drop < 8'd255) exp_drop = exp_drop + 8'd1;
      exp_busy = (win.size() != 0);
    end
    rst     = rs;
    enable  = en;
    s_valid = sv;
    s_data  = d;
    m_ready = rdy;
    ovf_clr = clr;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (m_valid_u !== 1'b0 || m_valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_m_valid: got %b/%b want 0", m_valid_u, m_valid_s);
    end
    n_tests++;
    if (m_data_u !== 16'h0 || m_data_s !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_m_data: got %h/%h want 0000", m_data_u, m_data_s);
    end
    n_tests++;
    if (drop_cnt_u !== 8'd0 || busy_u !== 1'b0 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop_busy: got drop=%0d busy=%b/%b want 0/0", drop_cnt_u, busy_u, busy_s);
    end
  endtask

  task automatic test_unsigned_avg;
    logic [15:0] want;
`ifdef ADC_AVG_ROUND_EN
    want = 16'd102;
`else
    want = 16'd101;
`endif
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'(100 + i), 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (m_valid_u !== 1'b1 || m_data_u !== want) begin
      n_fail++;
      $display("FAIL unsigned_avg: got valid=%b data=%0d want valid=1 data=%0d", m_valid_u, m_data_u, want);
    end
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (m_valid_u !== 1'b0 || m_data_u !== want) begin
      n_fail++;
      $display("FAIL unsigned_pulse: got valid=%b data=%0d want valid=0 data=%0d", m_valid_u, m_data_u, want);
    end
  endtask

  task automatic test_signed_avg;
    logic [15:0] want;
`ifdef ADC_AVG_ROUND_EN
    want = 16'hFFFE;
`else
    want = 16'hFFFD;
`endif
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'hFFFF - 16'(i), 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (m_valid_s !== 1'b1 || m_data_s !== want) begin
      n_fail++;
      $display("FAIL signed_avg: got valid=%b data=%h want valid=1 data=%h", m_valid_s, m_data_s, want);
    end
    n_tests++;
    if (m_data_u !== exp_data_u) begin
      n_fail++;
      $display("FAIL unsigned_of_neg: got %h want %h", m_data_u, exp_data_u);
    end
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (m_valid_u !== 1'b1 || m_data_u !== 16'h1000) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%b data=%h want valid=1 data=1000", m_valid_u, m_data_u);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (drop_cnt_u !== 8'd1 || drop_cnt_s !== 8'd1 || m_valid_u !== 1'b1 || m_data_u !== 16'h1000) begin
      n_fail++;
      $display("FAIL bp_drop: got drop=%0d/%0d valid=%b data=%h want drop=1 valid=1 data=1000",
               drop_cnt_u, drop_cnt_s, m_valid_u, m_data_u);
    end
    cycle(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (drop_cnt_u !== 8'd0 || m_valid_u !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_clear: got drop=%0d valid=%b want drop=0 valid=1", drop_cnt_u, m_valid_u);
    end
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_drop_saturate;
    for (int i = 0; i < N * 258; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (drop_cnt_u !== 8'd255 || drop_cnt_s !== 8'd255) begin
      n_fail++;
      $display("FAIL drop_saturate: got %0d/%0d want 255", drop_cnt_u, drop_cnt_s);
    end
    for (int i = 0; i < N - 1; i++) cycle(1'b1, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'd7, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (drop_cnt_u !== 8'd1) begin
      n_fail++;
      $display("FAIL clr_with_drop: got %0d want 1", drop_cnt_u);
    end
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (m_valid_u !== 1'b1 || m_data_u !== exp_data_u || m_data_s !== exp_data_s || drop_cnt_u !== 8'd0) begin
      n_fail++;
      $display("FAIL back_to_back: got valid=%b data=%h/%h drop=%0d want valid=1 data=%h/%h drop=0",
               m_valid_u, m_data_u, m_data_s, drop_cnt_u, exp_data_u, exp_data_s);
    end
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush;
    cycle(1'b1, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (busy_u !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy_set: got %b want 1", busy_u);
    end
    cycle(1'b1, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (busy_u !== 1'b0 || m_valid_u !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy_clr: got busy=%b valid=%b want 0/0", busy_u, m_valid_u);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (m_valid_u !== 1'b1 || m_data_u !== 16'h0200 || m_data_s !== 16'h0200) begin
      n_fail++;
      $display("FAIL flush_result: got valid=%b data=%h/%h want 1 0200", m_valid_u, m_data_u, m_data_s);
    end
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (m_valid_u !== 1'b1 || busy_u !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got valid=%b busy=%b want 1/1", m_valid_u, busy_u);
    end
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (m_valid_u !== 1'b0 || m_data_u !== 16'h0 || busy_u !== 1'b0 || drop_cnt_u !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b data=%h busy=%b drop=%0d want 0", m_valid_u, m_data_u, busy_u, drop_cnt_u);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (m_valid_u !== 1'b1 || m_data_u !== 16'hFFFF || m_data_s !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL top_code: got valid=%b data=%h/%h want 1 ffff", m_valid_u, m_data_u, m_data_s);
    end
    cycle(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic en, sv, rdy, clr, rs;
    for (int i = 0; i < 2000; i++) begin
      en  = ($urandom_range(0, 15) != 0);
      sv  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      cycle(en, sv, 16'($urandom), rdy, clr, rs);
      n_tests++;
      if (m_valid_u !== exp_valid || m_valid_s !== exp_valid || m_data_u !== exp_data_u ||
          m_data_s !== exp_data_s || drop_cnt_u !== exp_drop || drop_cnt_s !== exp_drop ||
          busy_u !== exp_busy || busy_s !== exp_busy) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%b/%b d=%h/%h drop=%0d/%0d busy=%b/%b want v=%b d=%h/%h drop=%0d busy=%b",
                 i, m_valid_u, m_valid_s, m_data_u, m_data_s, drop_cnt_u, drop_cnt_s, busy_u, busy_s,
                 exp_valid, exp_data_u, exp_data_s, exp_drop, exp_busy);
      end
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp_valid  = 1'b0;
    exp_data_u = 16'd0;
    exp_data_s = 16'd0;
    exp_drop   = 8'd0;
    exp_busy   = 1'b0;
    rst        = 1'b1;
    enable     = 1'b0;
    s_valid    = 1'b0;
    s_data     = 16'd0;
    m_ready    = 1'b0;
    ovf_clr    = 1'b0;
    test_reset();
    test_unsigned_avg();
    test_signed_avg();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_drop_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
